// File: rtl/toggle_decoder.sv
// -----------------------------------------------------------------------------
// toggle_decoder
//
// Receive side of a toggle-encoded event link. The remote transmitter flips
// its output level once per event. This block brings that level into the
// local clock domain, turns each level change into a one-cycle pulse, and
// queues the events in a saturating pending counter. A consumer drains the
// counter with a valid/ack handshake. The block also keeps a wrapping event
// total and a sticky overflow flag.
//
// Parameters
//   SYNC_STAGES : synchroniser depth on tog_in (2 or more)
//   CNT_W       : width of the pending and total counters
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset of all state
//   tog_in     in   toggle-encoded level, asynchronous to clk
//   clear      in   synchronous clear of pending, evt_total and overflow
//   evt_ack    in   consumer takes one pending event
//   pulse_out  out  one-cycle pulse per detected tog_in transition
//   evt_valid  out  high while pending is non-zero
//   pending    out  events detected but not yet acknowledged (saturating)
//   evt_total  out  events detected since reset/clear (wraps)
//   overflow   out  sticky: an event was dropped because pending was full
// -----------------------------------------------------------------------------
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    input  logic             clear,
    input  logic             evt_ack,
    output logic             pulse_out,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic [CNT_W-1:0] evt_total,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   tog_prev_r;
    logic                   tog_sync_s;
    logic                   edge_s;

    logic [CNT_W-1:0]       pending_r;
    logic [CNT_W-1:0]       total_r;
    logic                   overflow_r;

    logic [CNT_W-1:0]       pending_nxt_s;
    logic [CNT_W-1:0]       total_nxt_s;
    logic                   overflow_nxt_s;

    assign tog_sync_s = sync_r[SYNC_STAGES-1];

    // Both operands are flop outputs, so the pulse is glitch-free and lasts
    // exactly one cycle per settled level change.
    assign edge_s     = tog_sync_s ^ tog_prev_r;

    assign pulse_out  = edge_s;
    assign pending    = pending_r;
    assign evt_total  = total_r;
    assign overflow   = overflow_r;
    assign evt_valid  = (pending_r != CNT_ZERO);

    // Synchroniser chain: tog_in enters at bit 0, tog_sync is the top bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], tog_in};
        end
    end

    // Reference level; resetting it to 0 matches the transmitter's reset
    // level, so a tog_in already at 1 when reset releases yields one event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_prev_r <= 1'b0;
        end else begin
            tog_prev_r <= tog_sync_s;
        end
    end

    // Next-state logic for pending, total and overflow in priority order.
    always_comb begin
        pending_nxt_s  = pending_r;
        total_nxt_s    = total_r;
        overflow_nxt_s = overflow_r;
        if (clear) begin
            // Clear wins over a coincident edge, including a saturating one.
            pending_nxt_s  = CNT_ZERO;
            total_nxt_s    = CNT_ZERO;
            overflow_nxt_s = 1'b0;
        end else if (edge_s) begin
            total_nxt_s = total_r + CNT_ONE;
            if (evt_ack && evt_valid) begin
                // One event in, one event out.
                pending_nxt_s = pending_r;
            end else if (pending_r == PEND_MAX) begin
                // Counter full: the event is lost but still counted in total.
                pending_nxt_s  = pending_r;
                overflow_nxt_s = 1'b1;
            end else begin
                // Also covers edge+ack at zero: the ack is ignored.
                pending_nxt_s = pending_r + CNT_ONE;
            end
        end else if (evt_ack && evt_valid) begin
            pending_nxt_s = pending_r - CNT_ONE;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r  <= CNT_ZERO;
            total_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            total_r    <= total_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

endmodule

// File: tb/tb_toggle_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_decoder
//
// Drives two toggle_decoder instances with identical stimulus: one with
// CNT_W=8 and one with CNT_W=3 (for saturation). A behavioural model tracks
// the expected event count: an input level change becomes visible as an
// event SYNC_STAGES edges after it is sampled, and the pending count is
// pending + arrivals - accepted_acks, clamped to the counter maximum.
// -----------------------------------------------------------------------------
module tb_toggle_decoder;

    localparam int S = 2;

    logic       clk;
    logic       reset;
    logic       tog_in;
    logic       clear;
    logic       evt_ack;

    logic       pulse_a, valid_a, ovf_a;
    logic [7:0] pend_a, tot_a;
    logic       pulse_b, valid_b, ovf_b;
    logic [2:0] pend_b, tot_b;

    int checks = 0;
    int errors = 0;

    toggle_decoder #(.SYNC_STAGES(S), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .tog_in(tog_in), .clear(clear),
        .evt_ack(evt_ack), .pulse_out(pulse_a), .evt_valid(valid_a),
        .pending(pend_a), .evt_total(tot_a), .overflow(ovf_a)
    );

    toggle_decoder #(.SYNC_STAGES(S), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .tog_in(tog_in), .clear(clear),
        .evt_ack(evt_ack), .pulse_out(pulse_b), .evt_valid(valid_b),
        .pending(pend_b), .evt_total(tot_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uniform views of both instances for looped comparisons.
    logic [7:0] d_pend [2];
    logic [7:0] d_tot  [2];
    logic       d_valid[2];
    logic       d_ovf  [2];
    logic       d_pulse[2];

    always_comb begin
        d_pend[0]  = pend_a;
        d_pend[1]  = {5'd0, pend_b};
        d_tot[0]   = tot_a;
        d_tot[1]   = {5'd0, tot_b};
        d_valid[0] = valid_a;
        d_valid[1] = valid_b;
        d_ovf[0]   = ovf_a;
        d_ovf[1]   = ovf_b;
        d_pulse[0] = pulse_a;
        d_pulse[1] = pulse_b;
    end

    // ---------------- reference model ----------------
    int m_pend[2];
    int m_tot [2];
    bit m_ovf [2];
    int m_max [2] = '{255, 7};
    bit m_pulse;
    bit hist[0:S];     // hist[0] = most recent sampled tog_in
    int m_np;
    bit m_edge;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_tot[i]  = 0;
            m_ovf[i]  = 1'b0;
        end
        for (int j = 0; j <= S; j++) hist[j] = 1'b0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step();
        if (reset) begin
            model_reset();
            return;
        end
        m_edge = hist[S-1] ^ hist[S];
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_pend[i] = 0;
                m_tot[i]  = 0;
                m_ovf[i]  = 1'b0;
            end else begin
                m_np = m_pend[i] + (m_edge ? 1 : 0) - ((evt_ack && m_pend[i] > 0) ? 1 : 0);
                if (m_np > m_max[i]) begin
                    m_np     = m_max[i];
                    m_ovf[i] = 1'b1;
                end
                m_pend[i] = m_np;
                if (m_edge) m_tot[i] = (m_tot[i] + 1) % (m_max[i] + 1);
            end
        end
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = tog_in;
        m_pulse = hist[S-1] ^ hist[S];
    endfunction

    // One clock cycle: model updates at the rising edge, bench resumes on the
    // falling edge where outputs are sampled and inputs are changed.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle_wait();
        tog_in = ~tog_in;
        ticks(4);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; tog_in = 1'b0; clear = 1'b0; evt_ack = 1'b0;
        model_reset();
        ticks(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({d_pulse[i], d_valid[i], d_ovf[i], d_pend[i], d_tot[i]} !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b expected all zero", i,
                         {d_pulse[i], d_valid[i], d_ovf[i], d_pend[i], d_tot[i]});
            end
        end
        reset = 1'b0;
        ticks(4);
        checks++;
        if (pend_a !== 8'd0 || pulse_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got pend %0d pulse %b expected 0 0", pend_a, pulse_a);
        end
    endtask

    task automatic test_single_event();
        tog_in = 1'b1;
        tick();
        checks++;
        if (pulse_a !== 1'b0) begin errors++; $display("FAIL single_pulse_early: got %b expected 0", pulse_a); end
        tick();
        checks++;
        if (pulse_a !== 1'b1) begin errors++; $display("FAIL single_pulse_high: got %b expected 1", pulse_a); end
        tick();
        checks++;
        if (pulse_a !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", pulse_a); end
        checks++;
        if (pend_a !== 8'd1 || tot_a !== 8'd1 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL single_counts: got pend %0d tot %0d valid %b expected 1 1 1", pend_a, tot_a, valid_a);
        end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        checks++;
        if (pend_a !== 8'd0 || valid_a !== 1'b0 || tot_a !== 8'd1) begin
            errors++;
            $display("FAIL single_ack: got pend %0d valid %b tot %0d expected 0 0 1", pend_a, valid_a, tot_a);
        end
    endtask

    task automatic test_burst_drain();
        do_clear();
        repeat (5) toggle_wait();
        checks++;
        if (pend_a !== 8'd5 || tot_a !== 8'd5) begin
            errors++;
            $display("FAIL burst_counts: got pend %0d tot %0d expected 5 5", pend_a, tot_a);
        end
        evt_ack = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            tick();
            checks++;
            if (pend_a !== 8'(k)) begin
                errors++;
                $display("FAIL drain_step: got %0d expected %0d", pend_a, k);
            end
        end
        ticks(2);
        evt_ack = 1'b0;
        checks++;
        if (pend_a !== 8'd0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL drain_extra_ack: got pend %0d valid %b expected 0 0", pend_a, valid_a);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        repeat (9) toggle_wait();
        checks++;
        if (pend_b !== 3'd7 || ovf_b !== 1'b1 || tot_b !== 3'd1) begin
            errors++;
            $display("FAIL sat_narrow: got pend %0d ovf %b tot %0d expected 7 1 1", pend_b, ovf_b, tot_b);
        end
        checks++;
        if (pend_a !== 8'd9 || ovf_a !== 1'b0 || tot_a !== 8'd9) begin
            errors++;
            $display("FAIL sat_wide: got pend %0d ovf %b tot %0d expected 9 0 9", pend_a, ovf_a, tot_a);
        end
        do_clear();
        checks++;
        if (pend_b !== 3'd0 || ovf_b !== 1'b0 || tot_b !== 3'd0 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got pend %0d ovf %b tot %0d valid %b expected 0 0 0 0",
                     pend_b, ovf_b, tot_b, valid_b);
        end
    endtask

    task automatic test_simultaneous();
        do_clear();
        repeat (2) toggle_wait();
        tog_in = ~tog_in;
        ticks(2);
        checks++;
        if (pulse_a !== 1'b1) begin errors++; $display("FAIL simul_pulse: got %b expected 1", pulse_a); end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        checks++;
        if (pend_a !== 8'd2 || tot_a !== 8'd3) begin
            errors++;
            $display("FAIL simul_nonzero: got pend %0d tot %0d expected 2 3", pend_a, tot_a);
        end
        evt_ack = 1'b1;
        ticks(2);
        evt_ack = 1'b0;
        tog_in = ~tog_in;
        ticks(2);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        checks++;
        if (pend_a !== 8'd1 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL simul_zero: got pend %0d valid %b expected 1 1", pend_a, valid_a);
        end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
    endtask

    task automatic test_clear_collision();
        do_clear();
        repeat (8) toggle_wait();
        checks++;
        if (pend_b !== 3'd7 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL collide_presat: got pend %0d ovf %b expected 7 1", pend_b, ovf_b);
        end
        tog_in = ~tog_in;
        ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d_pend[i] !== 8'd0 || d_tot[i] !== 8'd0 || d_ovf[i] !== 1'b0) begin
                errors++;
                $display("FAIL collide_clear[%0d]: got pend %0d tot %0d ovf %b expected 0 0 0",
                         i, d_pend[i], d_tot[i], d_ovf[i]);
            end
        end
        repeat (4) begin
            tick();
            checks++;
            if (pulse_a !== 1'b0 || pend_a !== 8'd0) begin
                errors++;
                $display("FAIL collide_quiet: got pulse %b pend %0d expected 0 0", pulse_a, pend_a);
            end
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        if (tog_in) toggle_wait();
        do_clear();
        repeat (3) toggle_wait();
        checks++;
        if (pend_a !== 8'd3 || tog_in !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: got pend %0d tog %b expected 3 1", pend_a, tog_in);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({d_pulse[i], d_valid[i], d_ovf[i], d_pend[i], d_tot[i]} !== 19'd0) begin
                errors++;
                $display("FAIL areset_immediate[%0d]: got %b expected all zero", i,
                         {d_pulse[i], d_valid[i], d_ovf[i], d_pend[i], d_tot[i]});
            end
        end
        tick();
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            tick();
            if (pulse_a === 1'b1) pulses++;
        end
        checks++;
        if (pend_a !== 8'd1 || tot_a !== 8'd1 || pulses != 1) begin
            errors++;
            $display("FAIL areset_release: got pend %0d tot %0d pulses %0d expected 1 1 1",
                     pend_a, tot_a, pulses);
        end
    endtask

    task automatic test_random();
        int hold;
        int ack_pct;
        hold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hold == 0) begin
                tog_in = ~tog_in;
                hold = int'($urandom_range(3, 7));
            end else begin
                hold--;
            end
            ack_pct = (cyc < 200) ? 12 : 50;
            evt_ack = (int'($urandom_range(0, 99)) < ack_pct);
            clear   = ($urandom_range(0, 63) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_pend[i] !== 8'(m_pend[i]) || d_tot[i] !== 8'(m_tot[i]) ||
                    d_ovf[i] !== m_ovf[i] || d_pulse[i] !== m_pulse ||
                    d_valid[i] !== (m_pend[i] != 0)) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got pend %0d tot %0d ovf %b pulse %b valid %b expected %0d %0d %b %b %b",
                             i, cyc, d_pend[i], d_tot[i], d_ovf[i], d_pulse[i], d_valid[i],
                             m_pend[i], m_tot[i], m_ovf[i], m_pulse, (m_pend[i] != 0));
                end
            end
        end
        evt_ack = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst_drain();
        test_saturation();
        test_simultaneous();
        test_clear_collision();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
